// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - read-side controller of the asynchronous FIFO (rclk domain)
module fifo_rd_ctrl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [ADDRSIZE:0]   rlevel
);

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] wbin;
    logic              pop;

    // Pop whenever memory holds data and the output stage is free or being drained.
    always_comb begin
        pop       = !rempty && (!dout_valid || dout_ready);
        rbinnext  = rbin + {{ADDRSIZE{1'b0}}, pop};
        rgraynext = (rbinnext >> 1) ^ rbinnext;
    end

    // Gray-to-binary of the synchronized write pointer; bit i is the XOR of bits i and above.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end
    end

    // Memory is addressed by the current pointer, so the word popped this edge is already on mem_rdata.
    assign raddr = rbin[ADDRSIZE-1:0];

    // Pointer, empty flag and occupancy registers; empty compares full pointers including the wrap bit.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            rlevel <= '0;
        end else begin
            rbin   <= rbinnext;
            rptr   <= rgraynext;
            rempty <= (rgraynext == rq2_wptr);
            rlevel <= wbin - rbinnext;
        end
    end

    // Output register: refill on pop, release on acceptance, otherwise hold.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (pop) begin
            dout       <= mem_rdata;
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - scoreboard bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

    localparam int DS    = 8;
    localparam int AS    = 4;
    localparam int DEPTH = 16;

    logic          rclk   = 1'b0;
    logic          rrst_n = 1'b1;
    logic [AS:0]   rq2_wptr;
    logic [DS-1:0] mem_rdata;
    logic [AS-1:0] raddr;
    logic [AS:0]   rptr;
    logic          rempty;
    logic [DS-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [AS:0]   rlevel;

    logic [DS-1:0] mem [DEPTH];
    logic [DS-1:0] sb_q[$];
    logic [AS:0]   wcnt;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            accepted = 0;
    int            written  = 0;

    fifo_rd_ctrl #(.DATASIZE(DS), .ADDRSIZE(AS)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rq2_wptr   (rq2_wptr),
        .mem_rdata  (mem_rdata),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .rlevel     (rlevel)
    );

    always #5 rclk = ~rclk;

    assign mem_rdata = mem[raddr];

    function automatic logic [AS:0] gray(input logic [AS:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DS-1:0] d);
        mem[wcnt[AS-1:0]] = d;
        sb_q.push_back(d);
        wcnt     = wcnt + (AS+1)'(1);
        written++;
        rq2_wptr = gray(wcnt);
    endtask

    task automatic step();
        logic [DS-1:0] e;
        if (dout_valid && dout_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_word", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("sb_data", 32'(dout), 32'(e));
                accepted++;
            end
        end
        @(posedge rclk);
        #1;
    endtask

    task automatic apply_reset(input bit clear_wr);
        rrst_n = 1'b0;
        #1;
        check("rst_rempty", 32'(rempty), 32'd1);
        check("rst_rptr", 32'(rptr), 32'd0);
        check("rst_raddr", 32'(raddr), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_rlevel", 32'(rlevel), 32'd0);
        sb_q.delete();
        accepted = 0;
        if (clear_wr) begin
            wcnt     = '0;
            rq2_wptr = '0;
            written  = 0;
        end
        rrst_n = 1'b1;
    endtask

    task automatic drain(input int max_cycles);
        dout_ready = 1'b1;
        for (int i = 0; i < max_cycles && (sb_q.size() != 0 || dout_valid); i++) step();
        check("drain_queue", 32'(sb_q.size()), 32'd0);
        check("drain_valid", 32'(dout_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AS:0] prev;
        bit          saw_wrap;
        bit          pushed;

        dout_ready = 1'b0;
        rq2_wptr   = '0;
        wcnt       = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        #2;
        apply_reset(1'b1);

        // single word
        dout_ready = 1'b1;
        push_word(8'hA5);
        step();
        check("sw_rempty_k", 32'(rempty), 32'd0);
        check("sw_valid_k", 32'(dout_valid), 32'd0);
        check("sw_rlevel_k", 32'(rlevel), 32'd1);
        step();
        check("sw_valid_k1", 32'(dout_valid), 32'd1);
        check("sw_dout_k1", 32'(dout), 32'hA5);
        check("sw_raddr_k1", 32'(raddr), 32'd1);
        check("sw_rptr_k1", 32'(rptr), 32'b00001);
        check("sw_rempty_k1", 32'(rempty), 32'd1);
        step();
        check("sw_valid_after", 32'(dout_valid), 32'd0);

        // back-pressure
        apply_reset(1'b1);
        dout_ready = 1'b0;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        step();
        step();
        check("bp_first_dout", 32'(dout), 32'h11);
        check("bp_first_rlevel", 32'(rlevel), 32'd2);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_stall_dout", 32'(dout), 32'h11);
            check("bp_stall_valid", 32'(dout_valid), 32'd1);
            check("bp_stall_raddr", 32'(raddr), 32'd1);
            check("bp_stall_rptr", 32'(rptr), 32'b00001);
        end
        dout_ready = 1'b1;
        step();
        check("bp_dout2", 32'(dout), 32'h22);
        check("bp_rlevel2", 32'(rlevel), 32'd1);
        step();
        check("bp_dout3", 32'(dout), 32'h33);
        check("bp_rlevel3", 32'(rlevel), 32'd0);
        check("bp_rempty3", 32'(rempty), 32'd1);
        drain(4);

        // burst jump Gray(0) -> Gray(16)
        apply_reset(1'b1);
        dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_word(8'($urandom));
        step();
        check("burst_rlevel", 32'(rlevel), 32'd16);
        check("burst_rempty0", 32'(rempty), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            step();
            check("burst_valid", 32'(dout_valid), 32'd1);
            check("burst_rempty", 32'(rempty), 32'(i == 16));
        end
        check("burst_rlevel_end", 32'(rlevel), 32'd0);
        drain(4);

        // wrap-around over 40 words
        apply_reset(1'b1);
        dout_ready = 1'b1;
        prev       = rptr;
        saw_wrap   = 1'b0;
        for (int it = 0; it < 300 && accepted < 40; it++) begin
            pushed = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (written - accepted < 16 && written < 40) begin
                    push_word(8'(written * 7 + 3));
                    pushed = 1'b1;
                end
            end
            step();
            check("wrap_rptr_onebit", 32'($countones(rptr ^ prev) > 1), 32'd0);
            if (prev == 5'b10000 && rptr == 5'b00000) saw_wrap = 1'b1;
            prev = rptr;
            if (pushed) check("wrap_no_empty", 32'(rempty), 32'd0);
        end
        check("wrap_accepted", 32'(accepted), 32'd40);
        check("wrap_seen", 32'(saw_wrap), 32'd1);
        check("wrap_raddr_end", 32'(raddr), 32'd8);
        check("wrap_rptr_end", 32'(rptr), 32'(gray(5'd8)));
        check("wrap_rempty_end", 32'(rempty), 32'd1);
        drain(4);

        // reset mid-burst
        apply_reset(1'b1);
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(8'(8'hC0 + i));
        step();
        for (int i = 0; i < 5; i++) step();
        check("mid_valid_before", 32'(dout_valid), 32'd1);
        apply_reset(1'b0);
        for (int i = 0; i < 8; i++) sb_q.push_back(mem[i]);
        step();
        check("mid_rempty_after", 32'(rempty), 32'd0);
        check("mid_rlevel_after", 32'(rlevel), 32'd8);
        drain(20);

        check("final_queue", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
